// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and make/break decoder feeding the card-game control FSM.
// Ports:
//   clk, resetn          system clock, async active-low reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 lines
//   keyboard[7:0]        make code of the last accepted key press
//   go                   high while the key in keyboard is held
//   rx_byte[7:0]         last correctly received raw byte
//   rx_valid             one-cycle pulse when rx_byte updates
//   frame_err            one-cycle pulse on parity, stop-bit or timeout error
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard,
  output logic       go,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [1:0] KB_NORMAL  = 2'd0;
  localparam logic [1:0] KB_BRK     = 2'd1;
  localparam logic [1:0] KB_EXT     = 2'd2;
  localparam logic [1:0] KB_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Synchronizers and edge detect
  logic             r_clk_s1, r_clk_s2, r_clk_d;
  logic             r_dat_s1, r_dat_s2;
  logic             w_fall;
  logic             w_dat;

  // Receive FSM state
  logic [1:0]       r_rx_state, w_rx_state_nx;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic             r_parity, w_parity_nx;
  logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_nx;
  logic             w_good, w_bad;

  // Byte handler state
  logic [1:0]       r_kb_state, w_kb_state_nx;
  logic [7:0]       w_keyboard_nx;
  logic             w_go_nx;
  logic             w_nonkey;

  // Two-flop synchronizers, idle-high reset so no false edge leaves reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_d & ~r_clk_s2;
  assign w_dat  = r_dat_s2;

  // Receive FSM next state; a falling edge always beats the timeout
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_bit_cnt_nx  = r_bit_cnt;
    w_shift_nx    = r_shift;
    w_parity_nx   = r_parity;
    w_idle_cnt_nx = r_idle_cnt;
    w_good        = 1'b0;
    w_bad         = 1'b0;
    if (w_fall) begin
      w_idle_cnt_nx = '0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_dat) begin
            w_rx_state_nx = RX_DATA;
            w_bit_cnt_nx  = '0;
          end
        end
        RX_DATA: begin
          w_shift_nx   = {w_dat, r_shift[7:1]};
          w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == BIT_W'(7)) begin
            w_rx_state_nx = RX_PARITY;
          end
        end
        RX_PARITY: begin
          w_parity_nx   = w_dat;
          w_rx_state_nx = RX_STOP;
        end
        default: begin
          w_rx_state_nx = RX_IDLE;
          if ((r_parity == ~^r_shift) && w_dat) begin
            w_good = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
      endcase
    end else if (r_rx_state != RX_IDLE) begin
      if (r_idle_cnt == TIMEOUT_LAST) begin
        w_rx_state_nx = RX_IDLE;
        w_idle_cnt_nx = '0;
        w_bad         = 1'b1;
      end else begin
        w_idle_cnt_nx = r_idle_cnt + CNT_W'(1);
      end
    end
  end

  // Codes the keyboard sends that are never key presses
  always_comb begin
    w_nonkey = 1'b0;
    case (r_shift)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: w_nonkey = 1'b1;
      default:                                  w_nonkey = 1'b0;
    endcase
  end

  // Byte handler next state; r_shift holds the full byte when w_good fires
  always_comb begin
    w_kb_state_nx = r_kb_state;
    w_keyboard_nx = keyboard;
    w_go_nx       = go;
    if (w_bad) begin
      w_kb_state_nx = KB_NORMAL;
    end else if (w_good) begin
      case (r_kb_state)
        KB_NORMAL: begin
          if (r_shift == CODE_EXT) begin
            w_kb_state_nx = KB_EXT;
          end else if (r_shift == CODE_BRK) begin
            w_kb_state_nx = KB_BRK;
          end else if (!w_nonkey) begin
            w_keyboard_nx = r_shift;
            w_go_nx       = 1'b1;
          end
        end
        KB_BRK: begin
          if (r_shift == keyboard) begin
            w_go_nx = 1'b0;
          end
          w_kb_state_nx = KB_NORMAL;
        end
        KB_EXT: begin
          if (r_shift == CODE_BRK) begin
            w_kb_state_nx = KB_EXT_BRK;
          end else begin
            w_kb_state_nx = KB_NORMAL;
          end
        end
        default: begin
          w_kb_state_nx = KB_NORMAL;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_idle_cnt <= '0;
      r_kb_state <= KB_NORMAL;
      keyboard   <= '0;
      go         <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_shift    <= w_shift_nx;
      r_parity   <= w_parity_nx;
      r_idle_cnt <= w_idle_cnt_nx;
      r_kb_state <= w_kb_state_nx;
      keyboard   <= w_keyboard_nx;
      go         <= w_go_nx;
      if (w_good) begin
        rx_byte <= r_shift;
      end
      rx_valid   <= w_good;
      frame_err  <= w_bad;
    end
  end

endmodule
